fetch_sequencer: RTL and testbench



---
 rtl/fetch_sequencer.sv | 106 ++++++++++
 tb/tb_fetch_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: PC generation, sync-RAM reads, prefetch buffer, decode handshake.
// Optional FETCH_PERF_EN adds saturating pop/stall counters.
module fetch_sequencer #(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 4,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              halt,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_re,
  input  logic [DATA_W-1:0] imem_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
`ifdef FETCH_PERF_EN
  output logic [15:0]       perf_fetched,
  output logic [15:0]       perf_stall,
`endif
  output logic [ADDR_W-1:0] inst_pc
);
  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;
  localparam logic [OW-1:0] DEPTH_C = OW'(DEPTH);
  localparam logic [1:0] IDLE = 2'd0, FETCH = 2'd1, HALTED = 2'd2;

  logic [1:0]        state;
  logic [ADDR_W-1:0] pc, issued_pc;
  logic              inflight;
  logic [PW-1:0]     head, tail;
  logic [OW-1:0]     occ, fill;
  logic [DATA_W-1:0] buf_data [DEPTH];
  logic [ADDR_W-1:0] buf_pc   [DEPTH];
  logic              redir, push, pop;

  // fill uses the pre-pop occupancy so a full buffer never over-issues
  assign fill       = occ + OW'(inflight);
  assign redir      = redirect & (state != IDLE);
  assign imem_re    = !reset & (state == FETCH) & !halt & !redirect & (fill < DEPTH_C);
  assign imem_addr  = pc;
  assign inst_valid = (occ != '0);
  assign pop        = inst_valid & inst_ready;
  assign push       = inflight & !redir;
  assign inst_data  = inst_valid ? buf_data[head] : '0;
  assign inst_pc    = inst_valid ? buf_pc[head]   : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pc        <= ADDR_W'(RESET_PC);
      issued_pc <= '0;
      inflight  <= 1'b0;
    end else begin
      case (state)
        IDLE:    state <= FETCH;
        FETCH:   if (halt) state <= HALTED;
        HALTED:  if (!halt) state <= FETCH;
        default: state <= IDLE;
      endcase
      if (redir)        pc <= redirect_addr;
      else if (imem_re) pc <= pc + 1'b1;
      if (imem_re) issued_pc <= pc;
      inflight <= imem_re;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else if (redir) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      if (push && !pop)      occ <= occ + 1'b1;
      else if (!push && pop) occ <= occ - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_data[tail] <= imem_data;
      buf_pc[tail]   <= issued_pc;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (pop && perf_fetched != 16'hFFFF) perf_fetched <= perf_fetched + 1'b1;
      if (inst_valid && !inst_ready && perf_stall != 16'hFFFF) perf_stall <= perf_stall + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: stimulus queues expected words, a negedge monitor checks pops.
module tb_fetch_sequencer;
  logic        clk, reset, halt, redirect, inst_ready, imem_re, inst_valid;
  logic [3:0]  redirect_addr, imem_addr, inst_pc;
  logic [31:0] imem_data, inst_data;
`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetched, perf_stall;
`endif

  fetch_sequencer #(.ADDR_W(4), .DATA_W(32), .DEPTH(4), .RESET_PC(0)) dut (
    .clk(clk), .reset(reset), .halt(halt), .redirect(redirect),
    .redirect_addr(redirect_addr), .imem_addr(imem_addr), .imem_re(imem_re),
    .imem_data(imem_data), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data),
`ifdef FETCH_PERF_EN
    .perf_fetched(perf_fetched), .perf_stall(perf_stall),
`endif
    .inst_pc(inst_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (imem_re) imem_data <= 32'hA000_0000 + {28'h0, imem_addr};

  typedef struct { logic [3:0] pc; logic [31:0] data; } exp_t;
  exp_t exp_q [$];

  int s_checks = 0, s_errors = 0, m_checks = 0, m_errors = 0;
  int pops = 0, re_cnt = 0, gaps = 0;
  logic stream_on;

  always @(negedge clk) begin
    if (imem_re) re_cnt++;
    if (stream_on && !inst_valid) gaps++;
    if (!reset && inst_valid && inst_ready) begin
      pops++;
      m_checks++;
      if (exp_q.size() == 0) begin
        m_errors++;
        $display("FAIL unexpected_pop: got pc %0d, required no word", inst_pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (inst_pc !== e.pc || inst_data !== e.data) begin
          m_errors++;
          $display("FAIL pop_word: got pc %0d data %h, required pc %0d data %h",
                   inst_pc, inst_data, e.pc, e.data);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    s_checks++;
    if (act !== req) begin
      s_errors++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  task automatic push_seq(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.pc   = 4'(first + i);
      e.data = 32'hA000_0000 + {28'h0, e.pc};
      exp_q.push_back(e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // leaves the bench 1ns into the first post-reset (IDLE) cycle
  task automatic do_reset();
    inst_ready = 1'b0; halt = 1'b0; redirect = 1'b0; redirect_addr = 4'h0;
    stream_on = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic wait_first_valid(output int lat);
    lat = 0;
    while (1) begin
      step();
      lat++;
      if (inst_valid) break;
      if (lat > 50) begin
        chk("first_valid_timeout", 64'(lat), 64'd3);
        break;
      end
    end
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      step();
      n++;
    end
    chk(nm, 64'(exp_q.size()), 64'd0);
    inst_ready = 1'b0;
    stream_on  = 1'b0;
  endtask

  initial begin
    int lat, base_re, base_gap, base_pop;
    // stream with wrap, reset state, first-word latency
    do_reset();
    chk("rst_imem_re", 64'(imem_re), 64'd0);
    chk("rst_inst_valid", 64'(inst_valid), 64'd0);
    chk("rst_inst_data", 64'(inst_data), 64'd0);
    chk("rst_inst_pc", 64'(inst_pc), 64'd0);
    chk("rst_pc", 64'(imem_addr), 64'd0);
    push_seq(0, 20);
    inst_ready = 1'b1;
    wait_first_valid(lat);
    chk("t1_latency", 64'(lat), 64'd3);
    chk("t1_first_pc", 64'(inst_pc), 64'd0);
    base_gap = gaps;
    stream_on = 1'b1;
    drain("t1_drain");
    chk("t1_gaps", 64'(gaps - base_gap), 64'd0);

    // backpressure fills the buffer, then resumes without gap or repeat
    do_reset();
    base_re = re_cnt; base_pop = pops;
    push_seq(0, 12);
    wait_first_valid(lat);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 9) begin
        chk("t2_issued_full", 64'(re_cnt - base_re), 64'd4);
        chk("t2_re_stalled", 64'(imem_re), 64'd0);
        chk("t2_no_pop", 64'(pops - base_pop), 64'd0);
      end
      step();
    end
    base_gap = gaps;
    inst_ready = 1'b1;
    stream_on = 1'b1;
    drain("t2_drain");
    chk("t2_gaps", 64'(gaps - base_gap), 64'd0);
`ifdef FETCH_PERF_EN
    chk("t6_perf_stall", 64'(perf_stall), 64'd10);
    chk("t6_perf_fetched", 64'(perf_fetched), 64'(pops - base_pop));
`endif

    // redirect to 9 mid-stream: pc4 pops in the redirect cycle, pc5 in flight is dropped
    do_reset();
    push_seq(0, 5);
    push_seq(9, 6);
    inst_ready = 1'b1;
    wait_first_valid(lat);
    repeat (4) step();
    redirect = 1'b1; redirect_addr = 4'h9;
    #1 chk("t3_no_issue", 64'(imem_re), 64'd0);
    step();
    redirect = 1'b0;
    #1 chk("t3_issue_re", 64'(imem_re), 64'd1);
    chk("t3_issue_addr", 64'(imem_addr), 64'd9);
    chk("t3_n1_valid", 64'(inst_valid), 64'd0);
    step();
    chk("t3_n2_valid", 64'(inst_valid), 64'd0);
    step();
    chk("t3_n3_valid", 64'(inst_valid), 64'd1);
    chk("t3_n3_pc", 64'(inst_pc), 64'd9);
    drain("t3_drain");

    // halt for 5 cycles: no reads, buffer drains, pc holds
    do_reset();
    push_seq(0, 10);
    inst_ready = 1'b1;
    wait_first_valid(lat);
    repeat (2) step();
    halt = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_halt_re", 64'(imem_re), 64'd0);
      if (i == 4) begin
        chk("t4_drained", 64'(inst_valid), 64'd0);
        chk("t4_pc_held", 64'(imem_addr), 64'd4);
      end
      step();
    end
    halt = 1'b0;
    drain("t4_drain");

    // reset wins over a same-cycle redirect with 3 words buffered
    do_reset();
    wait_first_valid(lat);
    repeat (2) step();
    reset = 1'b1; redirect = 1'b1; redirect_addr = 4'h9;
    step();
    reset = 1'b0; redirect = 1'b0;
    #1 chk("t5_valid", 64'(inst_valid), 64'd0);
    chk("t5_pc", 64'(imem_addr), 64'd0);
    chk("t5_idle_re", 64'(imem_re), 64'd0);
    push_seq(0, 4);
    inst_ready = 1'b1;
    step();
    chk("t5_fetch_re", 64'(imem_re), 64'd1);
    chk("t5_fetch_addr", 64'(imem_addr), 64'd0);
    drain("t5_drain");

    repeat (2) step();
    $display("Simulation finished: %0d checks, %0d errors", s_checks + m_checks, s_errors + m_errors);
    $finish;
  end
endmodule
